// File: rtl/bcd_word_converter.sv
// bcd_word_converter: converts a packed BCD word to unsigned binary. It handles one
// digit per clock, starting with the most significant digit. A single shared
// bcd_to_binary digit converter feeds an acc*10 + digit accumulator.
// Optional feature: define BCD_WORD_CONV_ERR_CHECK_EN to enable invalid-digit detection.

module bcd_word_converter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned OUT_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [OUT_W-1:0]      bin_out,
  output logic                  error
);

  localparam int unsigned WORD_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_q;
  logic [OUT_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;

  logic [3:0]          digit_c;
  logic [3:0]          digit_val_c;
  logic [OUT_W-1:0]    acc_x10_c;
  logic [OUT_W-1:0]    acc_next_c;

`ifdef BCD_WORD_CONV_ERR_CHECK_EN
  logic                digit_bad_c;
  logic                err_flag;
`endif

  // Select the digit addressed by the down-counter (MSD first)
  assign digit_c = word_q[{cnt, 2'b00} +: 4];

  // One digit converter, time-shared across all digit positions
  bcd_to_binary u_digit (
    .digit     (digit_c),
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
    .invalid_c (digit_bad_c),
`endif
    .value_c   (digit_val_c)
  );

  // acc*10 as shift-add; truncation modulo 2^OUT_W is intentional
  assign acc_x10_c  = (acc << 3) + (acc << 1);
  assign acc_next_c = acc_x10_c + OUT_W'(digit_val_c);

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      word_q  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
      err_flag <= 1'b0;
      error    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            word_q <= bcd_in;
            acc    <= '0;
            cnt    <= CNT_W'(DIGITS - 1);
            busy   <= 1'b1;
            state  <= CONV;
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
            err_flag <= 1'b0;
`endif
          end
        end
        CONV: begin
          acc <= acc_next_c;
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
          err_flag <= err_flag | digit_bad_c;
`endif
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
          error   <= err_flag;
          bin_out <= err_flag ? '0 : acc;
`else
          bin_out <= acc;
`endif
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BCD_WORD_CONV_ERR_CHECK_EN
  // Without checking there is no error source
  assign error = 1'b0;
`endif

endmodule

// bcd_to_binary: single-digit converter. It passes the raw 4-bit value through and,
// when checking is enabled, flags codes 10..15.
module bcd_to_binary (
  input  logic [3:0] digit,
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
  output logic       invalid_c,
`endif
  output logic [3:0] value_c
);

  // A BCD digit's binary value equals its code
  assign value_c = digit;

`ifdef BCD_WORD_CONV_ERR_CHECK_EN
  // Codes above 9 are not BCD
  assign invalid_c = (digit > 4'd9);
`endif

endmodule

// File: tb/tb_bcd_word_converter.sv
// tb_bcd_word_converter: a scoreboard bench for bcd_word_converter with DIGITS=4 and OUT_W=14.
// The expected value is pushed when the bench drives start and is popped on each done pulse.

module tb_bcd_word_converter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned OUT_W  = 14;

  logic              clk;
  logic              reset;
  logic              start;
  logic [15:0]       bcd_in;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  bin_out;
  logic              error;

  int                checks;
  int                errors;
  int                done_cnt;
  int                cyc;
  logic              done_prev;
  logic [14:0]       exp_q[$];

  bcd_word_converter #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency and period measurement
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: {error, value} for a 4-digit word
  function automatic logic [14:0] model(input logic [15:0] w);
    int   a;
    logic bad;
    logic [15:0] tmp;
    a   = 0;
    bad = 1'b0;
    tmp = w;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'(tmp[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      a = (a * 10 + d) % 16384;
    end
`ifdef BCD_WORD_CONV_ERR_CHECK_EN
    if (bad) return {1'b1, 14'd0};
    return {1'b0, 14'(a)};
`else
    return {1'b0, 14'(a)};
`endif
  endfunction

  // Monitor: score every done pulse against the queue
  initial begin
    done_cnt  = 0;
    done_prev = 1'b0;
    forever begin
      logic [14:0] e;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        check("done_pulse_width", 32'(done_prev), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("bin_out", 32'(bin_out), 32'(e[13:0]));
          check("error", 32'(error), 32'(e[14]));
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_done(output int at, input int budget);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        at = cyc;
        return;
      end
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic convert(input logic [15:0] w);
    int ts;
    int td;
    @(negedge clk);
    bcd_in = w;
    start  = 1'b1;
    exp_q.push_back(model(w));
    @(posedge clk);
    #1;
    ts = cyc;
    check("busy_rise", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(td, 20);
    if (td >= 0) check("latency", 32'(td - ts), 32'd5);
  endtask

  initial begin
    int d0;
    int t[3];
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic conversions
    convert(16'h1234);
    repeat (3) @(posedge clk);
    #1;
    check("bin_out_hold", 32'(bin_out), 32'd1234);
    convert(16'h9999);
    convert(16'h0000);

    // Second start during CONV must be ignored
    @(negedge clk);
    bcd_in = 16'h0042;
    start  = 1'b1;
    exp_q.push_back(model(16'h0042));
    @(negedge clk);
    start  = 1'b0;
    d0     = done_cnt;
    @(negedge clk);
    bcd_in = 16'h0777;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_value", 32'(bin_out), 32'd42);

    // Reset in the third CONV cycle aborts without a done
    @(negedge clk);
    bcd_in = 16'h5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    d0     = done_cnt;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bin_out", 32'(bin_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    convert(16'h0010);

    // Invalid digit, then a clean conversion
    convert(16'h12A4);
    convert(16'h0001);

    // Start held high: back-to-back conversions every DIGITS+2 cycles
    for (int n = 0; n < 3; n++) exp_q.push_back(model(16'h0003));
    @(negedge clk);
    bcd_in = 16'h0003;
    start  = 1'b1;
    for (int n = 0; n < 3; n++) wait_done(t[n], 20);
    @(negedge clk);
    start = 1'b0;
    check("repeat_period_1", 32'(t[1] - t[0]), 32'd6);
    check("repeat_period_2", 32'(t[2] - t[1]), 32'd6);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
